// File: rtl/alarm_pkg.sv
// Shared encodings and defaults for the alarm set/ring controller.
package alarm_pkg;

  typedef enum logic [2:0] {
    MODE_RUN    = 3'd0,
    MODE_SET_CH = 3'd1,
    MODE_SET_CM = 3'd2,
    MODE_SET_AH = 3'd3,
    MODE_SET_AM = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    RING_IDLE   = 2'd0,
    RING_ACTIVE = 2'd1,
    RING_SNOOZE = 2'd2
  } ring_e;

  localparam int RING_SEC_DEF   = 60;
  localparam int SNOOZE_MIN_DEF = 5;

  function automatic mode_e mode_step(input mode_e m);
    case (m)
      MODE_RUN:    return MODE_SET_CH;
      MODE_SET_CH: return MODE_SET_CM;
      MODE_SET_CM: return MODE_SET_AH;
      MODE_SET_AH: return MODE_SET_AM;
      default:     return MODE_RUN;
    endcase
  endfunction

endpackage

// File: rtl/alarm_set_ctrl_if.sv
// Button/match inputs and increment/indicator outputs of the alarm controller.
interface alarm_set_ctrl_if;
  logic       tick_1hz;
  logic       mode_btn;
  logic       adj_btn;
  logic       alarm_on;
  logic       match;
  logic       clk_hour_inc;
  logic       clk_min_inc;
  logic       alm_hour_inc;
  logic       alm_min_inc;
  logic       sec_clr;
  logic [2:0] mode;
  logic       alarm_light;
  logic       blink;

  modport slave (
    input  tick_1hz, mode_btn, adj_btn, alarm_on, match,
    output clk_hour_inc, clk_min_inc, alm_hour_inc, alm_min_inc,
    output sec_clr, mode, alarm_light, blink
  );

  modport master (
    output tick_1hz, mode_btn, adj_btn, alarm_on, match,
    input  clk_hour_inc, clk_min_inc, alm_hour_inc, alm_min_inc,
    input  sec_clr, mode, alarm_light, blink
  );
endinterface

// File: rtl/btn_edge.sv
// Rising-edge detector; history resets high so a button held through reset is not an event.
module btn_edge (
  input  logic CLK,
  input  logic nCR,
  input  logic btn,
  output logic evt
);

  logic hist;

  always_ff @(posedge CLK or negedge nCR) begin
    if (!nCR) hist <= 1'b1;
    else      hist <= btn;
  end

  assign evt = btn & ~hist;

endmodule

// File: rtl/alarm_set_ctrl.sv
// Clock/alarm set-mode sequencer plus ring/snooze controller.
// mode:  RUN | normal display      SET_CH/CM/AH/AM | editing clock/alarm hour/minute
// ring:  IDLE | quiet   ACTIVE | ringing, light on   SNOOZE | waiting to re-ring
module alarm_set_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = RING_SEC_DEF,
  parameter int SNOOZE_MIN = SNOOZE_MIN_DEF
) (
  input logic             CLK,
  input logic             nCR,
  alarm_set_ctrl_if.slave bus
);

  localparam int SNOOZE_TICKS = SNOOZE_MIN * 60;
  localparam int RW = $clog2(RING_SEC + 1);
  localparam int SW = $clog2(SNOOZE_TICKS + 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC - 1);
  localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_TICKS - 1);

  logic mode_evt, adj_evt;

  btn_edge u_mode_edge (.CLK(CLK), .nCR(nCR), .btn(bus.mode_btn), .evt(mode_evt));
  btn_edge u_adj_edge  (.CLK(CLK), .nCR(nCR), .btn(bus.adj_btn),  .evt(adj_evt));

  mode_e         mode_q, mode_d;
  ring_e         ring_q, ring_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
  logic          fired_q, fired_d;
  logic [3:0]    inc_q, inc_d;
  logic          sec_clr_q, sec_clr_d;
  logic          blink_q, blink_d;
  logic          light_q;
  logic          busy;

  // Buttons belong to the ring controller whenever it is not idle
  assign busy = (ring_q != RING_IDLE);

  always_comb begin
    mode_d    = mode_q;
    inc_d     = '0;
    sec_clr_d = 1'b0;
    if (mode_q > MODE_SET_AM) begin
      mode_d = MODE_RUN;
    end else if (!busy) begin
      if (mode_evt) begin
        mode_d    = mode_step(mode_q);
        sec_clr_d = (mode_q == MODE_SET_CM);
      end else if (adj_evt) begin
        case (mode_q)
          MODE_SET_CH: inc_d[3] = 1'b1;
          MODE_SET_CM: inc_d[2] = 1'b1;
          MODE_SET_AH: inc_d[1] = 1'b1;
          MODE_SET_AM: inc_d[0] = 1'b1;
          default:     inc_d    = '0;
        endcase
      end
    end
    blink_d = (mode_d == MODE_RUN) ? 1'b0 : (blink_q ^ bus.tick_1hz);
  end

  always_ff @(posedge CLK or negedge nCR) begin
    if (!nCR) begin
      mode_q    <= MODE_RUN;
      inc_q     <= '0;
      sec_clr_q <= 1'b0;
      blink_q   <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      inc_q     <= inc_d;
      sec_clr_q <= sec_clr_d;
      blink_q   <= blink_d;
    end
  end

  always_comb begin
    ring_d     = ring_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    fired_d    = fired_q;
    if (mode_q == MODE_RUN && !bus.match) fired_d = 1'b0;
    if (!bus.alarm_on) begin
      ring_d = RING_IDLE;
    end else begin
      case (ring_q)
        RING_IDLE: begin
          // A same-cycle mode press wins so the alarm never rings outside RUN
          if (bus.match && mode_q == MODE_RUN && !fired_q && !mode_evt) begin
            ring_d     = RING_ACTIVE;
            ring_cnt_d = '0;
            fired_d    = 1'b1;
          end
        end
        RING_ACTIVE: begin
          if (mode_evt) begin
            ring_d = RING_IDLE;
          end else if (adj_evt) begin
            ring_d    = RING_SNOOZE;
            snz_cnt_d = '0;
          end else if (bus.tick_1hz) begin
            if (ring_cnt_q == RING_LAST) ring_d = RING_IDLE;
            else                         ring_cnt_d = ring_cnt_q + RW'(1);
          end
        end
        RING_SNOOZE: begin
          if (mode_evt) begin
            ring_d = RING_IDLE;
          end else if (bus.tick_1hz) begin
            if (snz_cnt_q == SNZ_LAST) begin
              ring_d     = RING_ACTIVE;
              ring_cnt_d = '0;
            end else begin
              snz_cnt_d = snz_cnt_q + SW'(1);
            end
          end
        end
        default: ring_d = RING_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nCR) begin
    if (!nCR) begin
      ring_q     <= RING_IDLE;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      fired_q    <= 1'b0;
      light_q    <= 1'b0;
    end else begin
      ring_q     <= ring_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      fired_q    <= fired_d;
      light_q    <= (ring_d == RING_ACTIVE);
    end
  end

  assign bus.clk_hour_inc = inc_q[3];
  assign bus.clk_min_inc  = inc_q[2];
  assign bus.alm_hour_inc = inc_q[1];
  assign bus.alm_min_inc  = inc_q[0];
  assign bus.sec_clr      = sec_clr_q;
  assign bus.mode         = mode_q;
  assign bus.alarm_light  = light_q;
  assign bus.blink        = blink_q;

endmodule
